// File: rtl/gray_conv_pkg.sv
// Shared types and constants for the Gray-code conversion arbiter.
package gray_conv_pkg;

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    localparam int COUNT_W = 16;

endpackage

// File: rtl/gray_conv_arbiter_gray2bin2.sv
// Combinational Gray-to-binary converter: bin bit k is the XOR of gray bits SIZE-1..k.
module gray2bin2 #(
    parameter int SIZE = 8
) (
    input  logic [SIZE-1:0] gray,
    output logic [SIZE-1:0] bin
);

    // Prefix XOR from the MSB downwards
    always_comb begin
        bin = '0;
        for (int k = 0; k < SIZE; k++) begin
            bin[k] = ^(gray >> k);
        end
    end

endmodule

// File: rtl/gray_conv_arbiter.sv
// Round-robin arbiter sharing one Gray-to-binary converter among NREQ requesters,
// with a single-entry result register and a saturating completion counter.
module gray_conv_arbiter
    import gray_conv_pkg::*;
#(
    parameter int SIZE = 8,
    parameter int NREQ = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*SIZE-1:0]     req_gray,
    output logic [NREQ-1:0]          req_ready,
    output logic                     rsp_valid,
    output logic [$clog2(NREQ)-1:0]  rsp_id,
    output logic [SIZE-1:0]          rsp_bin,
    input  logic                     rsp_ready,
    output logic [COUNT_W-1:0]       conv_count
);

    localparam int ID_W = $clog2(NREQ);

    state_t               state_r;
    state_t               state_nx_s;
    logic [ID_W-1:0]      rr_ptr_r;
    logic [ID_W-1:0]      rsp_id_r;
    logic [SIZE-1:0]      rsp_bin_r;
    logic [COUNT_W-1:0]   conv_count_r;

    logic                 can_accept_s;
    logic                 found_s;
    logic [ID_W-1:0]      gid_s;
    logic [NREQ-1:0]      grant_s;
    logic                 transfer_s;
    logic [SIZE-1:0]      sel_gray_s;
    logic [SIZE-1:0]      sel_bin_s;
    int                   idx_v;

    // Search for the first requester at or after rr_ptr, wrapping at NREQ
    always_comb begin
        can_accept_s = (state_r == EMPTY) || ((state_r == FULL) && rsp_ready);
        found_s      = 1'b0;
        gid_s        = '0;
        grant_s      = '0;
        idx_v        = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx_v = (int'(rr_ptr_r) + k) % NREQ;
            if (!found_s && req_valid[idx_v]) begin
                found_s = 1'b1;
                gid_s   = ID_W'(idx_v);
            end else begin
                found_s = found_s;
            end
        end
        if (can_accept_s && found_s) begin
            grant_s[gid_s] = 1'b1;
        end else begin
            grant_s = '0;
        end
        transfer_s = can_accept_s && found_s;
    end

    assign req_ready  = grant_s;
    assign sel_gray_s = req_gray[int'(gid_s)*SIZE +: SIZE];

    gray2bin2 #(
        .SIZE (SIZE)
    ) u_gray2bin2 (
        .gray (sel_gray_s),
        .bin  (sel_bin_s)
    );

    // Result-register occupancy; FULL persists across back-to-back transfers
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            EMPTY: begin
                if (transfer_s) begin
                    state_nx_s = FULL;
                end else begin
                    state_nx_s = EMPTY;
                end
            end
            FULL: begin
                if (rsp_ready && !transfer_s) begin
                    state_nx_s = EMPTY;
                end else begin
                    state_nx_s = FULL;
                end
            end
            default: state_nx_s = EMPTY;
        endcase
    end

    // State, pointer, result and counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= EMPTY;
            rr_ptr_r     <= '0;
            rsp_id_r     <= '0;
            rsp_bin_r    <= '0;
            conv_count_r <= '0;
        end else begin
            state_r <= state_nx_s;
            if (transfer_s) begin
                rr_ptr_r  <= (gid_s == ID_W'(NREQ - 1)) ? '0 : gid_s + 1'b1;
                rsp_id_r  <= gid_s;
                rsp_bin_r <= sel_bin_s;
            end
            if ((state_r == FULL) && rsp_ready && (conv_count_r != {COUNT_W{1'b1}})) begin
                conv_count_r <= conv_count_r + 1'b1;
            end
        end
    end

    assign rsp_valid  = (state_r == FULL);
    assign rsp_id     = rsp_id_r;
    assign rsp_bin    = rsp_bin_r;
    assign conv_count = conv_count_r;

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Scoreboard bench for gray_conv_arbiter: a reference arbiter model predicts grants
// and queues expected results that are checked when the DUT presents them.
module tb_gray_conv_arbiter;

    localparam int SIZE = 8;
    localparam int NREQ = 4;

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ*SIZE-1:0] req_gray;
    logic [NREQ-1:0]     req_ready;
    logic                rsp_valid;
    logic [1:0]          rsp_id;
    logic [SIZE-1:0]     rsp_bin;
    logic                rsp_ready;
    logic [15:0]         conv_count;

    gray_conv_arbiter #(.SIZE(SIZE), .NREQ(NREQ)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_gray   (req_gray),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_bin    (rsp_bin),
        .rsp_ready  (rsp_ready),
        .conv_count (conv_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] bin;
    } rsp_t;

    rsp_t        sb_q[$];
    int          vectors = 0;
    int          errors  = 0;
    logic        m_full;
    logic [1:0]  m_ptr;
    logic [15:0] m_count;

    function automatic logic [7:0] ref_bin(input logic [7:0] g);
        logic [7:0] b;
        b[7] = g[7];
        for (int k = 6; k >= 0; k--) b[k] = b[k+1] ^ g[k];
        return b;
    endfunction

    // One clock: check DUT against the model at negedge, then advance the model
    task automatic cycle();
        logic [3:0] exp_ready;
        int         gi;
        int         idx;
        logic       can;
        @(negedge clk);
        exp_ready = 4'b0000;
        gi  = -1;
        can = !m_full || rsp_ready;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(m_ptr) + k) % NREQ;
            if (gi < 0 && req_valid[idx]) gi = idx;
        end
        if (can && gi >= 0) exp_ready[gi] = 1'b1;
        else gi = -1;
        if (!rst) begin
            vectors++;
            if (req_ready !== exp_ready) begin
                errors++;
                $display("FAIL req_ready: got %b expected %b", req_ready, exp_ready);
            end
            vectors++;
            if (rsp_valid !== m_full) begin
                errors++;
                $display("FAIL rsp_valid: got %b expected %b", rsp_valid, m_full);
            end
            if (m_full) begin
                vectors++;
                if ({rsp_id, rsp_bin} !== sb_q[0]) begin
                    errors++;
                    $display("FAIL rsp_data: got id=%0d bin=%h expected id=%0d bin=%h",
                             rsp_id, rsp_bin, sb_q[0].id, sb_q[0].bin);
                end
            end
            vectors++;
            if (conv_count !== m_count) begin
                errors++;
                $display("FAIL conv_count: got %h expected %h", conv_count, m_count);
            end
        end
        @(posedge clk);
        if (rst) begin
            m_full  = 1'b0;
            m_ptr   = 2'd0;
            m_count = 16'h0000;
            sb_q.delete();
        end else begin
            if (m_full && rsp_ready) begin
                void'(sb_q.pop_front());
                if (m_count != 16'hFFFF) m_count++;
            end
            if (gi >= 0) begin
                sb_q.push_back({2'(gi), ref_bin(req_gray[gi*SIZE +: SIZE])});
                m_ptr  = 2'((gi + 1) % NREQ);
                m_full = 1'b1;
            end else if (m_full && rsp_ready) begin
                m_full = 1'b0;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 4'b0000; req_gray = 32'h0; rsp_ready = 1'b0;
        m_full = 1'b0; m_ptr = 2'd0; m_count = 16'h0000;
        cycle(); cycle();
        rst = 1'b0;
        cycle();
        vectors++;
        if (rsp_bin !== 8'h00 || rsp_id !== 2'd0 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got bin=%h id=%0d valid=%b expected 00/0/0",
                     rsp_bin, rsp_id, rsp_valid);
        end
    endtask

    task automatic test_single();
        req_valid = 4'b0001; req_gray[7:0] = 8'hC0; rsp_ready = 1'b0;
        #1;
        vectors++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL single_grant: got %b expected 0001", req_ready);
        end
        cycle();
        req_valid = 4'b0000;
        vectors++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_bin !== 8'h80) begin
            errors++;
            $display("FAIL single_rsp: got valid=%b id=%0d bin=%h expected 1/0/80",
                     rsp_valid, rsp_id, rsp_bin);
        end
        rsp_ready = 1'b1;
        cycle();
        rsp_ready = 1'b0;
    endtask

    task automatic test_round_robin();
        logic [3:0] want;
        rst = 1'b1; cycle(); rst = 1'b0;
        req_gray = $urandom;
        req_valid = 4'b1111; rsp_ready = 1'b1;
        for (int j = 0; j < 5; j++) begin
            #1;
            want = 4'b0001 << (j % NREQ);
            vectors++;
            if (req_ready !== want) begin
                errors++;
                $display("FAIL rr_order[%0d]: got %b expected %b", j, req_ready, want);
            end
            cycle();
        end
        req_valid = 4'b0000;
        cycle();
        rsp_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [9:0] held;
        req_gray = $urandom;
        req_valid = 4'b0001; rsp_ready = 1'b0;
        cycle();
        held = {rsp_id, rsp_bin};
        req_valid = 4'b0100;
        for (int j = 0; j < 3; j++) begin
            #1;
            vectors++;
            if (req_ready !== 4'b0000) begin
                errors++;
                $display("FAIL stall_ready[%0d]: got %b expected 0000", j, req_ready);
            end
            cycle();
            vectors++;
            if ({rsp_id, rsp_bin} !== held) begin
                errors++;
                $display("FAIL stall_stable[%0d]: got %h expected %h", j, {rsp_id, rsp_bin}, held);
            end
        end
        rsp_ready = 1'b1;
        #1;
        vectors++;
        if (req_ready !== 4'b0100) begin
            errors++;
            $display("FAIL release_grant: got %b expected 0100", req_ready);
        end
        cycle();
        req_valid = 4'b0000;
        vectors++;
        if (rsp_id !== 2'd2) begin
            errors++;
            $display("FAIL release_id: got %0d expected 2", rsp_id);
        end
        cycle();
        rsp_ready = 1'b0;
    endtask

    task automatic test_gray_sweep();
        req_valid = 4'b0001; rsp_ready = 1'b1;
        for (int g = 0; g < 256; g++) begin
            req_gray[7:0] = 8'(g);
            cycle();
            if (g == 8'h80) begin
                vectors++;
                if (rsp_bin !== 8'hFF) begin
                    errors++;
                    $display("FAIL gray_80: got %h expected ff", rsp_bin);
                end
            end
            if (g == 0) begin
                vectors++;
                if (rsp_bin !== 8'h00) begin
                    errors++;
                    $display("FAIL gray_00: got %h expected 00", rsp_bin);
                end
            end
        end
        req_valid = 4'b0000;
        cycle();
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset_full();
        req_valid = 4'b0001; rsp_ready = 1'b0;
        cycle();
        rst = 1'b1; req_valid = 4'b0010; rsp_ready = 1'b1;
        cycle();
        rst = 1'b0; req_valid = 4'b0000; rsp_ready = 1'b0;
        vectors++;
        if (rsp_valid !== 1'b0 || conv_count !== 16'h0000) begin
            errors++;
            $display("FAIL reset_full: got valid=%b count=%h expected 0/0000", rsp_valid, conv_count);
        end
        req_valid = 4'b1111;
        #1;
        vectors++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL reset_ptr: got %b expected 0001", req_ready);
        end
        cycle();
        req_valid = 4'b0000; rsp_ready = 1'b1;
        cycle();
        rsp_ready = 1'b0;
    endtask

    task automatic test_saturation();
        req_valid = 4'b1111; rsp_ready = 1'b1;
        while (m_count < 16'hFFFE) cycle();
        vectors++;
        if (conv_count !== 16'hFFFE) begin
            errors++;
            $display("FAIL count_fffe: got %h expected fffe", conv_count);
        end
        for (int j = 0; j < 3; j++) cycle();
        vectors++;
        if (conv_count !== 16'hFFFF) begin
            errors++;
            $display("FAIL count_sat: got %h expected ffff", conv_count);
        end
        req_valid = 4'b0000;
        cycle();
        rsp_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_gray_sweep();
        test_reset_full();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/gray_conv_arbiter.md
GRAY_CONV_ARBITER -- requirements
Module: gray_conv_arbiter

Interface
REQ-001 The block SHALL have parameter SIZE, default 8: code width in bits.
REQ-002 The block SHALL have parameter NREQ, default 4: number of requesters, range 2..8.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port req_valid, input, NREQ bits: per-requester request.
REQ-006 The block SHALL have port req_gray, input, NREQ*SIZE bits: per-requester Gray code; requester i uses slice [i*SIZE +: SIZE].
REQ-007 The block SHALL have port req_ready, output, NREQ bits: one-hot grant, asserted in the cycle the request is accepted.
REQ-008 The block SHALL have port rsp_valid, output, 1 bit: result register holds a valid result.
REQ-009 The block SHALL have port rsp_id, output, clog2(NREQ) bits: index of the requester owning the result.
REQ-010 The block SHALL have port rsp_bin, output, SIZE bits: binary equivalent of the granted Gray code.
REQ-011 The block SHALL have port rsp_ready, input, 1 bit: consumer accepts the result.
REQ-012 The block SHALL have port conv_count, output, 16 bits: saturating count of completed responses.

Function
REQ-013 The block SHALL share one Gray-to-binary converter among NREQ requesters through round-robin arbitration.
REQ-014 FSM states SHALL be EMPTY (result register free) and FULL (result register holds an undelivered result).
REQ-015 can_accept SHALL equal (state==EMPTY) or (state==FULL and rsp_ready).
REQ-016 When can_accept is true and any req_valid bit is set, req_ready SHALL assert for exactly one requester: the first set req_valid bit at or after rr_ptr, searching upward with wrap from NREQ-1 to 0.
REQ-017 req_ready SHALL be combinational from req_valid, rr_ptr and state, and SHALL be all-zero when can_accept is false or no req_valid bit is set.
REQ-018 A transfer SHALL occur when req_valid[i] and req_ready[i] are both high.
REQ-019 On a transfer, the next edge SHALL load rsp_bin = bin(req_gray[i]), where bit k = XOR of gray bits SIZE-1..k, and SHALL load rsp_id = i.
REQ-020 Latency SHALL be one cycle: rsp_valid is high in the cycle after a transfer.
REQ-021 On a transfer, rr_ptr SHALL become (i+1) mod NREQ; otherwise rr_ptr SHALL hold.
REQ-022 State transitions:
- EMPTY to FULL on a transfer.
- FULL to EMPTY on rsp_ready with no transfer.
- FULL stays FULL on rsp_ready with a transfer (back-to-back, throughput one per cycle).
- FULL holds on no rsp_ready.
REQ-023 While in FULL without rsp_ready, rsp_bin and rsp_id SHALL be stable.
REQ-024 A requester SHALL hold req_valid and req_gray until granted; the block SHALL NOT sample ungranted lanes.
REQ-025 conv_count SHALL increment when rsp_valid and rsp_ready are both high, saturating at 16'hFFFF.
REQ-026 rsp_valid SHALL be asserted exactly when state==FULL.

Reset
REQ-027 With rst high at a clock edge, the block SHALL set state=EMPTY, rr_ptr=0, rsp_bin=0, rsp_id=0 and conv_count=0; rsp_valid and req_ready SHALL then be 0.
REQ-028 Reset SHALL override any in-flight transfer: a held result is discarded and not counted.

Structure
REQ-029 Package gray_conv_pkg SHALL hold the state enum (EMPTY, FULL) and the COUNT_W=16 constant.
REQ-030 The conversion SHALL be one instantiated combinational sub-module gray2bin2 (parameter SIZE), fed by the arbiter-selected req_gray lane.

Verification
REQ-031 Reset, then req_valid=4'b0001 with gray 8'hC0 -> req_ready=4'b0001; next cycle rsp_valid=1, rsp_id=0, rsp_bin=8'h80.
REQ-032 req_valid=4'b1111 held with rsp_ready=1 -> grants in order 0,1,2,3,0 on consecutive cycles; one rsp per cycle.
REQ-033 FULL with rsp_ready=0 for 3 cycles and req_valid=4'b0100 -> req_ready=0 and rsp_bin stable; on rsp_ready=1, lane 2 is granted that same cycle.
REQ-034 Gray 8'h80 -> 8'hFF; gray 8'h00 -> 8'h00; exhaustive sweep of all 256 codes matches a reference model.
REQ-035 rst asserted while FULL -> next cycle rsp_valid=0, rr_ptr=0, conv_count=0.
REQ-036 Force conv_count to 16'hFFFE, then 3 handshakes -> conv_count=16'hFFFF.
